// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det_cnt.sv
// Saturating detection counter; holds at all-ones instead of wrapping.
module seq_det_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/seq_det.sv
// Overlapping 1011 serial detector with Mealy dout and optional saturating
// detection counter (build with SEQ_DET_CNT_EN defined to include it).
module seq_det
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  output logic             dout,
  output logic [CNT_W-1:0] det_count
);

  state_t present_state;
  state_t next_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) present_state <= S0;
    else        present_state <= next_state;
  end

  // Suffix-tracking transitions: each state is the longest matched prefix.
  always_comb begin
    next_state = S0;
    case (present_state)
      S0:      next_state = din ? S1 : S0;
      S1:      next_state = din ? S1 : S2;
      S2:      next_state = din ? S3 : S0;
      S3:      next_state = din ? S1 : S2;
      default: next_state = S0;
    endcase
  end

  // Mealy output: flags the fourth bit while it is still on din.
  always_comb begin
    dout = (present_state == S3) && (din == PATTERN[0]);
  end

`ifdef SEQ_DET_CNT_EN
  seq_det_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (dout),
    .count (det_count)
  );
`else
  assign det_count = '0;
`endif

endmodule

// File: tb/tb_seq_det.sv
// Self-checking bench for seq_det: directed and random din streams against a
// history-based reference model; a second instance uses CNT_W=2.
module tb_seq_det;

  logic       clock;
  logic       reset;
  logic       din;
  logic       dout;
  logic [7:0] det_count;
  logic       dout2;
  logic [1:0] det_count2;

  int checks = 0;
  int errors = 0;

  // Reference model state: recent bit history and total detections.
  logic [2:0] hist;
  int         nvalid;
  int         ndet;

  seq_det #(.CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .dout      (dout),
    .det_count (det_count)
  );

  seq_det #(.CNT_W(2)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .dout      (dout2),
    .det_count (det_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_dout(input logic b);
    return (nvalid >= 3) && ({hist, b} == 4'b1011);
  endfunction

  // Longest suffix of history that is a prefix of 1011.
  function automatic logic [1:0] model_state();
    if (nvalid >= 3 && hist == 3'b101) return 2'b11;
    if (nvalid >= 2 && hist[1:0] == 2'b10) return 2'b10;
    if (nvalid >= 1 && hist[0] == 1'b1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_cnt(input int max);
`ifdef SEQ_DET_CNT_EN
    return (ndet > max) ? max : ndet;
`else
    return (max >= 0) ? 0 : 0;
`endif
  endfunction

  function automatic void model_reset();
    hist   = 3'b000;
    nvalid = 0;
    ndet   = 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(dut.present_state), 32'(model_state()));
    check({tag, ".cnt8"}, 32'(det_count), model_cnt(255));
    check({tag, ".cnt2"}, 32'(det_count2), model_cnt(3));
  endtask

  // Drive one bit on the falling edge, check the Mealy output, clock it in.
  task automatic step(input logic b, input string tag);
    @(negedge clock);
    din = b;
    #1;
    check({tag, ".dout"}, 32'(dout), 32'(model_dout(b)));
    check({tag, ".dout2"}, 32'(dout2), 32'(model_dout(b)));
    @(posedge clock);
    if (model_dout(b)) ndet++;
    hist = {hist[1:0], b};
    if (nvalid < 3) nvalid++;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    din   = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".rst"});
    check({tag, ".rst.dout"}, 32'(dout), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    din   = 1'b0;
  endtask

  task automatic seq(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], tag);
  endtask

  initial begin
    model_reset();
    din   = 1'b0;
    reset = 1'b0;
    #2;
    check_all("por");
    check("por.dout", 32'(dout), 32'd0);

    // Basic detection after a leading 010.
    do_reset("basic");
    seq(16'b0101011, 7, "basic");
    check("basic.ndet", 32'(ndet), 32'd1);

    // Partial match discarded by reset, then a clean detection.
    do_reset("mid");
    seq(16'b10, 2, "mid.pre");
    do_reset("mid2");
    seq(16'b1011, 4, "mid.post");

    // Overlapping occurrences.
    do_reset("ovl");
    seq(16'b1011011, 7, "ovl");
    check("ovl.ndet", 32'(ndet), 32'd2);

    // Asynchronous reset between edges while in S3 with din=1.
    do_reset("async");
    seq(16'b101, 3, "async");
    @(negedge clock);
    din = 1'b1;
    #1;
    check("async.pre.dout", 32'(dout), 32'd1);
    check("async.pre.state", 32'(dut.present_state), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check("async.state", 32'(dut.present_state), 32'd0);
    check("async.dout", 32'(dout), 32'd0);
    check_all("async");
    @(negedge clock);
    reset = 1'b1;
    din   = 1'b0;

    // Saturation: five back-to-back non-overlapping patterns.
    do_reset("sat");
    for (int k = 0; k < 5; k++) seq(16'b1011, 4, "sat");
    check("sat.ndet", 32'(ndet), 32'd5);

    // Negative patterns never assert dout.
    do_reset("neg1");
    seq(16'b1111, 4, "neg1");
    do_reset("neg0");
    seq(16'b0000, 4, "neg0");
    do_reset("neg2");
    seq(16'b10011, 5, "neg2");
    check("neg.ndet", 32'(ndet), 32'd0);

    // Random stream with biased ones and occasional resets.
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      step(logic'($urandom_range(0, 2) != 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
